reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WRITE_BYPASS, default 1: when 1, a read of the register being written in the same cycle returns wr_data.
REQ-002 The block SHALL have parameter NUM_REGS, default 32: the architectural register count, fixed at 32 for rv32i.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 rd_addr_1  input  5 (reg_addr_t)  source register rs1; its data drives alu in_a.
REQ-006 rd_addr_2  input  5 (reg_addr_t)  source register rs2; its data drives alu in_b.
REQ-007 rd_data_1  output  32 (word_t)  contents of register rd_addr_1.
REQ-008 rd_data_2  output  32 (word_t)  contents of register rd_addr_2.
REQ-009 wr_en  input  1  write enable for the destination register.
REQ-010 wr_addr  input  5 (reg_addr_t)  destination register rd.
REQ-011 wr_data  input  32 (word_t)  write-back value, normally the alu result.

Function
REQ-012 Reads SHALL be combinational with zero-cycle latency from rd_addr_n to rd_data_n.
REQ-013 A write SHALL commit on the rising edge of clk when wr_en=1, rst_n=1 and wr_addr!=0, and be visible on the read ports from the next cycle.
REQ-014 Register x0 SHALL always read 32'h0; writes to wr_addr=0 SHALL be discarded, and no bypass SHALL apply to them.
REQ-015 With WRITE_BYPASS=1, when wr_en=1, wr_addr!=0 and rd_addr_n==wr_addr in the same cycle, rd_data_n SHALL equal wr_data combinationally.
REQ-016 With WRITE_BYPASS=0, in that same case rd_data_n SHALL return the old stored value.
REQ-017 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-018 When wr_en=0, no register SHALL change, whatever the values on wr_addr and wr_data.
REQ-019 Outputs SHALL never be X once rst_n has been sampled low at least once.

Reset
REQ-020 On a rising edge with rst_n=0, all registers x1..x31 SHALL be cleared to 32'h0, and any concurrent write SHALL be ignored.
REQ-021 While rst_n=0, the read ports SHALL still be combinational and SHALL return the current stored contents. After the first reset edge, that is 32'h0.
REQ-022 With WRITE_BYPASS=1, bypass SHALL be suppressed while rst_n=0, so reads reflect only stored state.
REQ-023 Deasserting reset mid-sequence SHALL require no recovery cycles: a write in the first cycle with rst_n=1 SHALL commit.

Structure
REQ-024 reg_addr_t (5-bit logic) and NUM_REGS SHALL be added to riscv_32i_defs_pkg, alongside the existing word_t.
REQ-025 Storage SHALL be one array of word_t, indexed by reg_addr_t, with x0 not implemented as storage.
REQ-026 No sub-module SHALL be used.
REQ-027 The bypass mux SHALL be generated under WRITE_BYPASS, with no logic when the parameter is 0.

Verification
REQ-028 Reset then read all addresses on both ports -> every rd_data reads 32'h0.
REQ-029 Write x5=32'hDEADBEEF, next cycle set rd_addr_1=5 and rd_addr_2=5 -> both ports read 32'hDEADBEEF.
REQ-030 wr_en=1, wr_addr=0, wr_data=32'hFFFFFFFF, with rd_addr_1=0 in the same and the next cycle -> reads 32'h0 both cycles.
REQ-031 x7=32'h1, then in the same cycle wr_en=1, wr_addr=7, wr_data=32'h2, rd_addr_1=7 -> rd_data_1 reads 32'h2 with WRITE_BYPASS=1 and 32'h1 with WRITE_BYPASS=0; both read 32'h2 the next cycle.
REQ-032 x3=32'h10, then rst_n=0 together with wr_en=1, wr_addr=3, wr_data=32'h55 -> x3 reads 32'h0 after the edge; with rst_n=1 and the same write the next cycle, x3 reads 32'h55.
REQ-033 Random writes and reads for at least 10k cycles checked against a reference model -> no mismatch; wr_en=0 cycles leave all 32 registers unchanged.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I type definitions.
//   word_t     : 32-bit architectural data word
//   reg_addr_t : 5-bit architectural register index (x0..x31)
//   NUM_REGS   : architectural register count for rv32i
package riscv_32i_defs_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_addr_t;

   localparam int NUM_REGS = 32;

endpackage : riscv_32i_defs_pkg

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports, one write port.
// x0 is hardwired to zero and has no storage behind it.
//
// Parameters
//   WRITE_BYPASS : 1 = a read of the register being written this cycle
//                  returns wr_data; 0 = it returns the old stored value
//   NUM_REGS     : architectural register count (32 for rv32i)
//
// Ports
//   clk        in   single clock, rising-edge
//   rst_n      in   synchronous active-low reset, clears x1..x31
//   rd_addr_1  in   rs1 index        rd_data_1  out  rs1 contents (alu in_a)
//   rd_addr_2  in   rs2 index        rd_data_2  out  rs2 contents (alu in_b)
//   wr_en      in   write enable
//   wr_addr    in   rd index
//   wr_data    in   write-back value
module reg_file
   import riscv_32i_defs_pkg::*;
#(
   parameter bit WRITE_BYPASS = 1'b1,
   parameter int NUM_REGS     = riscv_32i_defs_pkg::NUM_REGS
) (
   input  logic      clk,
   input  logic      rst_n,
   input  reg_addr_t rd_addr_1,
   input  reg_addr_t rd_addr_2,
   output word_t     rd_data_1,
   output word_t     rd_data_2,
   input  logic      wr_en,
   input  reg_addr_t wr_addr,
   input  word_t     wr_data
);

   word_t regs [1:NUM_REGS-1];
   word_t stored_1;
   word_t stored_2;

   // Reset wins over a concurrent write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // x0 has no storage, so the index is only used for non-zero addresses.
   always_comb begin
      stored_1 = '0;
      if (rd_addr_1 != '0) begin
         stored_1 = regs[rd_addr_1];
      end
   end

   always_comb begin
      stored_2 = '0;
      if (rd_addr_2 != '0) begin
         stored_2 = regs[rd_addr_2];
      end
   end

   if (WRITE_BYPASS) begin : g_bypass
      // Only a write that will actually commit is forwarded: not to x0,
      // and not while reset is holding the array.
      logic wr_live;
      assign wr_live   = rst_n && wr_en && (wr_addr != '0);
      assign rd_data_1 = (wr_live && (rd_addr_1 == wr_addr)) ? wr_data : stored_1;
      assign rd_data_2 = (wr_live && (rd_addr_2 == wr_addr)) ? wr_data : stored_2;
   end else begin : g_no_bypass
      assign rd_data_1 = stored_1;
      assign rd_data_2 = stored_2;
   end

endmodule : reg_file

// File: tb/tb_reg_file.sv
module tb_reg_file;
   import riscv_32i_defs_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n;
   reg_addr_t rd_addr_1, rd_addr_2, wr_addr;
   logic      wr_en;
   word_t     wr_data;
   word_t     rd1_b, rd2_b, rd1_n, rd2_n;

   int checks = 0;
   int errors = 0;

   // Reference: plain array of architectural values, x0 pinned to zero.
   word_t model [32];
   bit    armed = 1'b0;

   reg_file #(.WRITE_BYPASS(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
      .rd_data_1(rd1_b), .rd_data_2(rd2_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   reg_file #(.WRITE_BYPASS(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
      .rd_data_1(rd1_n), .rd_data_2(rd2_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic word_t expect_rd(input reg_addr_t a, input bit byp);
      if (a == 0) return '0;
      if (byp && rst_n && wr_en && (wr_addr == a)) return wr_data;
      return model[a];
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
         armed = 1'b1;
      end else if (wr_en && wr_addr != 0) begin
         model[wr_addr] = wr_data;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         check("model_rd1_bypass", rd1_b, expect_rd(rd_addr_1, 1'b1));
         check("model_rd2_bypass", rd2_b, expect_rd(rd_addr_2, 1'b1));
         check("model_rd1_nobypass", rd1_n, expect_rd(rd_addr_1, 1'b0));
         check("model_rd2_nobypass", rd2_n, expect_rd(rd_addr_2, 1'b0));
      end
   end

   task automatic cyc(input logic rn, input logic we, input reg_addr_t wa,
                      input word_t wd, input reg_addr_t a1, input reg_addr_t a2);
      @(posedge clk);
      #1;
      rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_addr_1 = a1; rd_addr_2 = a2;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_1 = '0; rd_addr_2 = '0;
      @(posedge clk);

      // During reset: write to x4 must neither bypass nor commit.
      cyc(1'b0, 1'b1, 5'd4, 32'hAAAA5555, 5'd4, 5'd4);
      @(negedge clk);
      check("rst_no_bypass", rd1_b, 32'h0);

      // Read every address on both ports after reset.
      for (int a = 0; a < 32; a++) begin
         cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
         @(negedge clk);
         check("reset_all_rd1", rd1_b, 32'h0);
         check("reset_all_rd2", rd2_n, 32'h0);
      end

      // x5 write, then read on both ports.
      cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      @(negedge clk);
      check("x5_rd1", rd1_b, 32'hDEADBEEF);
      check("x5_rd2", rd2_b, 32'hDEADBEEF);
      check("x5_rd1_nb", rd1_n, 32'hDEADBEEF);

      // Writes to x0 are discarded and never bypassed.
      cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      @(negedge clk);
      check("x0_same_cycle", rd1_b, 32'h0);
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
      @(negedge clk);
      check("x0_next_cycle", rd1_b, 32'h0);
      check("x5_kept", rd2_b, 32'hDEADBEEF);

      // Read-during-write on x7.
      cyc(1'b1, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
      cyc(1'b1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
      @(negedge clk);
      check("x7_bypass", rd1_b, 32'h2);
      check("x7_nobypass", rd1_n, 32'h1);
      cyc(1'b1, 1'b0, 5'd7, 32'h9, 5'd7, 5'd7);
      @(negedge clk);
      check("x7_next_b", rd1_b, 32'h2);
      check("x7_next_n", rd2_n, 32'h2);

      // Reset beats a concurrent write; first cycle out of reset commits.
      cyc(1'b1, 1'b1, 5'd3, 32'h10, 5'd0, 5'd0);
      cyc(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
      @(negedge clk);
      check("x3_in_rst_b", rd1_b, 32'h10);
      check("x3_in_rst_n", rd1_n, 32'h10);
      cyc(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
      @(negedge clk);
      check("x3_after_rst_n", rd1_n, 32'h0);
      check("x3_after_rst_b", rd1_b, 32'h55);
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
      @(negedge clk);
      check("x3_committed", rd1_n, 32'h55);
      check("x7_cleared", rd2_b, 32'h0);

      // Random traffic checked by the model every cycle.
      for (int n = 0; n < 10000; n++) begin
         reg_addr_t wa, a1, a2;
         logic      we, rn;
         wa = 5'($urandom_range(0, 31));
         we = ($urandom_range(0, 2) != 0);
         rn = ($urandom_range(0, 299) != 0);
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         cyc(rn, we, wa, $urandom, a1, a2);
      end
      @(posedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_file
